// File: rtl/nes_pad_reader_if.sv
// Pad-side wires and parallel result of nes_pad_reader.
// slave = reader, master = whatever drives the pad wires and consumes buttons.
interface nes_pad_reader_if;
  logic       enable;
  logic       pad_data;
  logic       pad_latch;
  logic       pad_clk;
  logic [7:0] buttons;
  logic       valid;
  logic       connected;

  modport master (
    output enable, pad_data,
    input  pad_latch, pad_clk, buttons, valid, connected
  );

  modport slave (
    input  enable, pad_data,
    output pad_latch, pad_clk, buttons, valid, connected
  );
endinterface

// File: rtl/nes_pad_reader.sv
// Periodically polls a 4021-based NES pad and deserializes its 8 buttons.
// Define NES_PAD_DETECT_EN to clock a 9th bit and report pad presence.
module nes_pad_reader #(
  parameter int unsigned HALF        = 6,
  parameter int unsigned POLL_PERIOD = 16667,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             res_n,
  nes_pad_reader_if.slave  pad
);
  localparam int unsigned      TW         = $clog2(POLL_PERIOD);
  localparam int unsigned      HW         = $clog2(HALF);
  localparam logic [TW-1:0]    TIMER_LAST = TW'(POLL_PERIOD - 1);
  localparam logic [HW-1:0]    HALF_LAST  = HW'(HALF - 1);
`ifdef NES_PAD_DETECT_EN
  // bit_cnt wraps 7->0 for the extra presence bit, which is the last one
  localparam logic [2:0]       LAST_BIT   = 3'd0;
`else
  localparam logic [2:0]       LAST_BIT   = 3'd7;
`endif

  typedef enum logic [2:0] {IDLE, LATCH, GAP, CLK_HI, CLK_LO, DONE} state_t;

  state_t                 state, state_next;
  logic [TW-1:0]          timer;
  logic [HW-1:0]          half_cnt;
  logic [2:0]             bit_cnt;
  logic [7:0]             shreg;
  logic [7:0]             buttons;
  logic                   connected;
  logic [SYNC_STAGES-1:0] sync;
  logic                   sample, wrap, half_end;

  assign sample   = sync[SYNC_STAGES-1];
  assign wrap     = (timer == TIMER_LAST);
  assign half_end = (half_cnt == HALF_LAST);

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n)          sync <= '1;
    else if (pad.enable) sync <= {sync[SYNC_STAGES-2:0], pad.pad_data};
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n)          timer <= '0;
    else if (pad.enable) timer <= wrap ? '0 : timer + 1'b1;
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n)          state <= IDLE;
    else if (pad.enable) state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (wrap)     state_next = LATCH;
      LATCH:   if (half_end) state_next = GAP;
      GAP:     if (half_end) state_next = CLK_HI;
      CLK_HI:  if (half_end) state_next = CLK_LO;
      CLK_LO:  if (half_end) state_next = (bit_cnt == LAST_BIT) ? DONE : CLK_HI;
      DONE:                  state_next = IDLE;
      default:               state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n)
      half_cnt <= '0;
    else if (pad.enable)
      half_cnt <= (state == IDLE || state == DONE || half_end) ? '0 : half_cnt + 1'b1;
  end

  // buttons is loaded on the edge entering DONE so it is already new while valid is high
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
      buttons <= '0;
    end else if (pad.enable && half_end) begin
      if (state == GAP) begin
        shreg   <= {sample, shreg[7:1]};
        bit_cnt <= 3'd1;
      end else if (state == CLK_LO) begin
        shreg   <= {sample, shreg[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == LAST_BIT) begin
`ifdef NES_PAD_DETECT_EN
          buttons <= sample ? '0 : ~shreg;
`else
          buttons <= ~{sample, shreg[7:1]};
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n)
      connected <= 1'b0;
`ifdef NES_PAD_DETECT_EN
    else if (pad.enable && half_end && state == CLK_LO && bit_cnt == LAST_BIT)
      connected <= ~sample;
`else
    else
      connected <= 1'b1;
`endif
  end

  always_comb begin
    pad.pad_latch = (state == LATCH);
    pad.pad_clk   = (state == CLK_HI);
    pad.valid     = (state == DONE) && pad.enable;
    pad.buttons   = buttons;
    pad.connected = connected;
  end
endmodule
